// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle for bcd_countdown_timer; master drives load/start/pause, slave returns the count.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   q;
  logic                  running;
  logic                  done;
  logic                  zero;

  modport master (
    output load, load_val, start, pause,
    input  q, running, done, zero
  );

  modport slave (
    input  load, load_val, start, pause,
    output q, running, done, zero
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Loadable BCD down-counter, one decrement every DIV running cycles, registered outputs (zero is combinational).
// Optional BCD_COUNTDOWN_AUTO_RELOAD_EN: terminal tick reloads from rld and keeps running instead of stopping.
module bcd_countdown_timer #(
  parameter int DIGITS = 4,
  parameter int DIV    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_countdown_timer_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [W-1:0]  Q_ONE      = W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state, state_n;
  logic [W-1:0]  q, q_n;
  logic [W-1:0]  rld, rld_n;
  logic [PW-1:0] presc, presc_n;
  logic          done_n;
  logic          running;
  logic          done;
  logic          tick;
  logic          go;

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple borrow: a zero digit wraps to 9 and passes the borrow upward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick = (presc == PRESC_LAST);
  // pause outranks start in every state, so a simultaneous pause blocks start.
  assign go   = bus.start && !bus.pause;

  always_comb begin
    state_n = state;
    q_n     = q;
    rld_n   = rld;
    presc_n = presc;
    done_n  = 1'b0;
    if (bus.load) begin
      q_n     = bcd_clamp(bus.load_val);
      rld_n   = bcd_clamp(bus.load_val);
      presc_n = '0;
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            if (q != '0) begin
              state_n = S_RUN;
              presc_n = '0;
            end else begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.pause) begin
            state_n = S_PAUSE;
          end else if (tick) begin
            presc_n = '0;
            if (q == Q_ONE) begin
              q_n     = '0;
              done_n  = 1'b1;
              state_n = S_DONE;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
              if (rld != '0) begin
                q_n     = rld;
                state_n = S_RUN;
              end
`endif
            end else begin
              q_n = bcd_dec(q);
            end
          end else begin
            presc_n = presc + 1'b1;
          end
        end
        S_PAUSE: begin
          if (go) state_n = S_RUN;
        end
        default: begin
          if (go) begin
            q_n = rld;
            if (rld != '0) begin
              state_n = S_RUN;
              presc_n = '0;
            end else begin
              done_n  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      q       <= '0;
      rld     <= '0;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      q       <= q_n;
      rld     <= rld_n;
      presc   <= presc_n;
      running <= (state_n == S_RUN);
      done    <= done_n;
    end
  end

  assign bus.q       = q;
  assign bus.running = running;
  assign bus.done    = done;
  assign bus.zero    = (q == '0);

endmodule
